// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for the 5-stage RV32I core.
// Produces stall/flush controls for the pipeline registers, EX operand
// forwarding selects, a sticky data-memory timeout flag and saturating
// stall/flush event counters.
//
// Handshake with data memory: an access is pending while the MEM stage holds a
// load or store (memreq). The access completes in any cycle where DMEM_READY is
// high together with memreq; until then the front of the pipeline is held and a
// bubble is fed into MEM/WB. If the wait reaches TIMEOUT cycles the access is
// abandoned, MEM_ERR latches and the pipeline is released.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int TMO_W   = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       RS1_FD,
    input  logic [4:0]       RS2_FD,
    input  logic             USE_RS1_FD,
    input  logic             USE_RS2_FD,
    input  logic [4:0]       RS1_DE,
    input  logic [4:0]       RS2_DE,
    input  logic [4:0]       RD_DE,
    input  logic             RegWrite_DE,
    input  logic [1:0]       MemRead_DE,
    input  logic             BrTaken_E,
    input  logic [4:0]       RD_EM,
    input  logic             RegWrite_EM,
    input  logic [1:0]       MemRead_EM,
    input  logic             MemWrite_EM,
    input  logic             DMEM_READY,
    input  logic [4:0]       RD_MW,
    input  logic             RegWrite_MW,
    output logic             STALL_IF,
    output logic             STALL_FD,
    output logic             STALL_DE,
    output logic             STALL_EM,
    output logic             FLUSH_FD,
    output logic             FLUSH_DE,
    output logic             FLUSH_MW,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic             MEM_ERR,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [TMO_W-1:0] wait_cnt, wait_cnt_nxt, wait_idx;
    logic             memreq, miss, timeout, memwait, loaduse, err_set;

    assign memreq = (MemRead_EM != 2'b00) | MemWrite_EM;
    assign miss   = memreq & ~DMEM_READY;

    // wait_idx is the 1-based index of the current non-ready cycle; the first
    // cycle of a wait is seen in RUN, later ones in WAIT.
    assign wait_idx = (state == WAIT) ? wait_cnt + TMO_W'(1) : TMO_W'(1);
    assign timeout  = miss & (wait_idx == TMO_W'(TIMEOUT));
    // Reset releases the pipeline immediately even if the access is still pending.
    assign memwait  = miss & ~timeout & ~RST;

    assign loaduse = (MemRead_DE != 2'b00) & RegWrite_DE & (RD_DE != 5'd0) &
                     ((USE_RS1_FD & (RD_DE == RS1_FD)) |
                      (USE_RS2_FD & (RD_DE == RS2_FD)));

    // Wait FSM next state and wait counter
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_set      = 1'b0;
        if (timeout) begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
            err_set      = 1'b1;
        end else if (miss) begin
            state_nxt    = WAIT;
            wait_cnt_nxt = wait_idx;
        end else begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
        end
    end

    // FSM state, wait counter and sticky error register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= RUN;
            wait_cnt <= '0;
            MEM_ERR  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (err_set) MEM_ERR <= 1'b1;
        end
    end

    // Stall/flush priority: memory wait, then taken branch, then load-use
    always_comb begin
        STALL_IF = 1'b0;
        STALL_FD = 1'b0;
        STALL_DE = 1'b0;
        STALL_EM = 1'b0;
        FLUSH_FD = 1'b0;
        FLUSH_DE = 1'b0;
        FLUSH_MW = 1'b0;
        if (memwait) begin
            STALL_IF = 1'b1;
            STALL_FD = 1'b1;
            STALL_DE = 1'b1;
            STALL_EM = 1'b1;
            FLUSH_MW = 1'b1;
        end else if (BrTaken_E) begin
            FLUSH_FD = 1'b1;
            FLUSH_DE = 1'b1;
        end else if (loaduse) begin
            STALL_IF = 1'b1;
            STALL_FD = 1'b1;
            FLUSH_DE = 1'b1;
        end
    end

    // EX operand forwarding: newest producer (EX/MEM) wins, x0 never forwarded
    always_comb begin
        FWD_A = 2'b00;
        FWD_B = 2'b00;
        if (RegWrite_EM && RD_EM != 5'd0 && RD_EM == RS1_DE)      FWD_A = 2'b01;
        else if (RegWrite_MW && RD_MW != 5'd0 && RD_MW == RS1_DE) FWD_A = 2'b10;
        if (RegWrite_EM && RD_EM != 5'd0 && RD_EM == RS2_DE)      FWD_B = 2'b01;
        else if (RegWrite_MW && RD_MW != 5'd0 && RD_MW == RS2_DE) FWD_B = 2'b10;
    end

    // Saturating stall and flush event counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            if (STALL_IF && STALL_CNT != '1) STALL_CNT <= STALL_CNT + CNT_W'(1);
            if (FLUSH_FD && FLUSH_CNT != '1) FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
        end
    end

endmodule
